// File: rtl/freq_meter_if.sv
// Result channel of freq_meter: a valid/ready port carrying the edge count
// of the last gate window and its saturation flag.
interface freq_meter_if #(
  parameter int CNT_W = 24
) ();
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] count_out;
  logic             overflow;

  modport master (
    output valid,
    output count_out,
    output overflow,
    input  ready
  );

  modport slave (
    input  valid,
    input  count_out,
    input  overflow,
    output ready
  );
endinterface

// File: rtl/freq_meter.sv
// freq_meter: counts edges of an asynchronous input over a fixed window of
// GATE_CYCLES clk cycles and offers the count on a valid/ready port.
// Optional build macro FREQ_METER_BOTH_EDGES_EN: when defined, both rising
// and falling transitions are counted; otherwise rising edges only.
//
// state | meaning
// IDLE  | waiting for start or cont
// ARM   | one cycle, clears gate counter, edge counter and saturation flag
// GATE  | counting edges for exactly GATE_CYCLES cycles
// HOLD  | result presented with valid=1 until the reader accepts it
module freq_meter #(
  parameter int GATE_CYCLES = 16000000,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  input  logic start,
  input  logic cont,
  output logic busy,
  freq_meter_if.master res
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_GATE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_out;
  logic                   edge_det;

  logic [1:0]       state_q,    state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q,      sat_d;
  logic             valid_q,    valid_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             ovf_q,      ovf_d;

  logic             edge_at_max;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;

  // Synchronize sig_in and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef FREQ_METER_BOTH_EDGES_EN
  assign edge_det = sync_out ^ hist_q;
`else
  assign edge_det = sync_out & ~hist_q;
`endif

  // Saturating edge count including the edge of the current cycle; the
  // counter sticks at its maximum rather than wrapping.
  always_comb begin
    edge_at_max = edge_det && (edge_cnt_q == CNT_MAX);
    cnt_next    = edge_cnt_q;
    if (edge_det && !edge_at_max) begin
      cnt_next = edge_cnt_q + 1'b1;
    end
    sat_next = sat_q | edge_at_max;
  end

  // Measurement sequencer and result register next-state logic.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    valid_d    = valid_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start || cont) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        state_d    = ST_GATE;
      end
      ST_GATE: begin
        edge_cnt_d = cnt_next;
        sat_d      = sat_next;
        if (gate_cnt_q == GATE_LAST) begin
          // The edge seen in the final gate cycle is part of the result.
          count_d = cnt_next;
          ovf_d   = sat_next;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        // Result stays put until accepted, so nothing is ever overwritten.
        if (valid_q && res.ready) begin
          valid_d = 1'b0;
          state_d = cont ? ST_ARM : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign res.valid     = valid_q;
  assign res.count_out = count_q;
  assign res.overflow  = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (24-bit and 4-bit counters, 100-cycle
// gate) driven by directed stimulus; a scoreboard queue per instance holds
// expected results that a monitor pops on every valid&ready transfer.
module tb_freq_meter;

`ifdef FREQ_METER_BOTH_EDGES_EN
  localparam int EXP_P10 = 20;
  localparam int EXP_P20 = 10;
`else
  localparam int EXP_P10 = 10;
  localparam int EXP_P20 = 5;
`endif

  typedef struct {
    int cnt;
    bit ovf;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  logic sig_a, sig_b;
  logic start_a, start_b, cont_a, cont_b;
  logic busy_a, busy_b;

  int checks = 0;
  int failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  int per_a = 0, per_b = 0;
  logic lvl_a = 1'b0, lvl_b = 1'b0;

  freq_meter_if #(.CNT_W(24)) if_a ();
  freq_meter_if #(.CNT_W(4))  if_b ();

  freq_meter #(.GATE_CYCLES(100), .CNT_W(24), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_a), .sig_in(sig_a), .start(start_a),
    .cont(cont_a), .busy(busy_a), .res(if_a)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_b), .sig_in(sig_b), .start(start_b),
    .cont(cont_b), .busy(busy_b), .res(if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Square-wave generators: toggle every per/2 cycles, or hold lvl if per==0.
  initial begin
    int ph;
    ph = 0;
    sig_a = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (per_a == 0) begin
        sig_a = lvl_a;
      end else begin
        ph++;
        if (ph >= per_a / 2) begin
          ph = 0;
          sig_a = ~sig_a;
        end
      end
    end
  end

  initial begin
    int ph;
    ph = 0;
    sig_b = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (per_b == 0) begin
        sig_b = lvl_b;
      end else begin
        ph++;
        if (ph >= per_b / 2) begin
          ph = 0;
          sig_b = ~sig_b;
        end
      end
    end
  end

  // Monitors: pop and compare on every transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_a && if_a.valid && if_a.ready) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_result", 1, 0);
        end else begin
          e = q_a.pop_front();
          chk("a_count", int'(if_a.count_out), e.cnt);
          chk("a_overflow", int'(if_a.overflow), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b && if_b.valid && if_b.ready) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_result", 1, 0);
        end else begin
          e = q_b.pop_front();
          chk("b_count", int'(if_b.count_out), e.cnt);
          chk("b_overflow", int'(if_b.overflow), int'(e.ovf));
        end
      end
    end
  end

  task automatic push_a(input int c, input bit o);
    exp_t e;
    e.cnt = c;
    e.ovf = o;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input bit o);
    exp_t e;
    e.cnt = c;
    e.ovf = o;
    q_b.push_back(e);
  endtask

  // Runs cycles from the issue cycle (start or transfer) until valid rises.
  // After the first edge, start drops and cont/ready take their follow-up values.
  task automatic run_to_valid_a(input logic cont_after, input logic ready_after,
                                output int n);
    n = 0;
    do begin
      tick(1);
      n++;
      if (n == 1) begin
        start_a = 1'b0;
        cont_a = cont_after;
        if_a.ready = ready_after;
        chk("a_valid_low_after_issue", int'(if_a.valid), 0);
      end
      if (n == 50) chk("a_busy_in_gate", int'(busy_a), 1);
    end while (!if_a.valid && n < 300);
  endtask

  task automatic thread_a();
    int n;
    int seen;
    rst_a = 1'b0;
    start_a = 1'b0;
    cont_a = 1'b0;
    if_a.ready = 1'b0;
    #1;
    chk("a_rst_busy", int'(busy_a), 0);
    chk("a_rst_valid", int'(if_a.valid), 0);
    chk("a_rst_count", int'(if_a.count_out), 0);
    chk("a_rst_overflow", int'(if_a.overflow), 0);
    tick(3);
    rst_a = 1'b1;

    // One-shot, period 10, latency check.
    per_a = 10;
    tick(30);
    push_a(EXP_P10, 1'b0);
    start_a = 1'b1;
    run_to_valid_a(1'b0, 1'b0, n);
    chk("a_oneshot_latency", n, 102);
    tick(3);
    chk("a_hold_valid_stays", int'(if_a.valid), 1);
    if_a.ready = 1'b1;
    tick(1);
    if_a.ready = 1'b0;
    chk("a_valid_drop", int'(if_a.valid), 0);
    chk("a_idle_after_xfer", int'(busy_a), 0);
    chk("a_count_kept", int'(if_a.count_out), EXP_P10);

    // Input held high: no edges; ready high before valid.
    per_a = 0;
    lvl_a = 1'b1;
    tick(30);
    push_a(0, 1'b0);
    if_a.ready = 1'b1;
    start_a = 1'b1;
    run_to_valid_a(1'b0, 1'b1, n);
    chk("a_held_latency", n, 102);
    tick(1);
    chk("a_held_valid_pulse", int'(if_a.valid), 0);
    chk("a_held_idle", int'(busy_a), 0);
    if_a.ready = 1'b0;

    // Continuous mode, reader stalls 50 cycles.
    per_a = 20;
    tick(30);
    push_a(EXP_P20, 1'b0);
    cont_a = 1'b1;
    run_to_valid_a(1'b1, 1'b0, n);
    chk("a_cont_latency", n, 102);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("a_stall_valid", int'(if_a.valid), 1);
      chk("a_stall_busy", int'(busy_a), 1);
      chk("a_stall_count", int'(if_a.count_out), EXP_P20);
      chk("a_stall_overflow", int'(if_a.overflow), 0);
    end
    push_a(EXP_P20, 1'b0);
    if_a.ready = 1'b1;
    run_to_valid_a(1'b0, 1'b0, n);
    chk("a_cont_next_latency", n, 102);
    if_a.ready = 1'b1;
    tick(1);
    if_a.ready = 1'b0;
    chk("a_cont_end_idle", int'(busy_a), 0);

    // Reset in the middle of a gate aborts it.
    per_a = 10;
    tick(30);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(41);
    rst_a = 1'b0;
    #1;
    chk("a_abort_busy", int'(busy_a), 0);
    chk("a_abort_valid", int'(if_a.valid), 0);
    chk("a_abort_count", int'(if_a.count_out), 0);
    chk("a_abort_overflow", int'(if_a.overflow), 0);
    if_a.ready = 1'b1;
    tick(3);
    rst_a = 1'b1;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (if_a.valid || busy_a) seen++;
    end
    chk("a_no_activity_after_abort", seen, 0);
    push_a(EXP_P10, 1'b0);
    start_a = 1'b1;
    run_to_valid_a(1'b0, 1'b1, n);
    chk("a_restart_latency", n, 102);
    tick(3);
  endtask

  task automatic wait_valid_b(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
      if (n == 1) start_b = 1'b0;
    end while (!if_b.valid && n < 300);
  endtask

  task automatic thread_b();
    int n;
    rst_b = 1'b0;
    start_b = 1'b0;
    cont_b = 1'b0;
    if_b.ready = 1'b1;
    #1;
    chk("b_rst_count", int'(if_b.count_out), 0);
    chk("b_rst_overflow", int'(if_b.overflow), 0);
    tick(3);
    rst_b = 1'b1;

    // 25 rising edges into a 4-bit counter: saturates.
    per_b = 4;
    tick(30);
    push_b(15, 1'b1);
    start_b = 1'b1;
    wait_valid_b(n);
    chk("b_sat_latency", n, 102);
    tick(3);
    chk("b_sat_count_kept", int'(if_b.count_out), 15);
    chk("b_sat_ovf_kept", int'(if_b.overflow), 1);

    // Below full scale: no overflow, and the flag clears for the new gate.
    per_b = 20;
    tick(30);
    push_b(EXP_P20, 1'b0);
    start_b = 1'b1;
    wait_valid_b(n);
    chk("b_low_latency", n, 102);
    tick(3);
  endtask

  initial begin
    fork
      thread_a();
      thread_b();
    join
    tick(5);
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a slow or asynchronous digital input, such as a PLL-derived clock, LED/strobe line or external reference.
- Counts the input's rising edges over a fixed gate window of system-clock cycles.
- The gate window is the same one-second tick the LED blinker uses (16,000,000 cycles).
- Presents the count on a valid/ready result port for a debug/UART reader.
- Sits beside the top-level LED drivers; it is the observing end of the signals they generate.

Parameters:
- GATE_CYCLES, 16000000: gate window length in clk cycles; minimum 4.
- CNT_W, 24: width of the edge counter and the result.
- SYNC_STAGES, 2: number of synchronizer flops on sig_in; minimum 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  1  signal under measurement; asynchronous to clk.
- start  in  1  one-shot request; sampled only in IDLE.
- cont  in  1  continuous mode; sampled in IDLE and HOLD.
- busy  out  1  high in ARM, GATE and HOLD.
- count_out  out  CNT_W  edges counted in the last gate.
- overflow  out  1  set when that count saturated.
- valid  out  1  result available.
- ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst_n low, asynchronous) clears everything:
  - state=IDLE, busy=0, valid=0, count_out=0, overflow=0;
  - synchronizer, edge register and all counters to 0.
- Reset asserted mid-gate or mid-HOLD aborts the measurement; no valid is produced.
- Input path: sig_in passes through SYNC_STAGES flops, then one history flop.
  - edge = sync_out & ~hist.
  - sig_in-to-edge latency is SYNC_STAGES+1 cycles.
  - Pulses narrower than one clk period may be lost; this is accepted.
- IDLE:
  - (start | cont)=1 -> ARM.
  - Otherwise stay in IDLE.
- ARM (1 cycle):
  - gate_cnt=0, edge_cnt=0, sat=0 -> GATE.
- GATE (exactly GATE_CYCLES cycles):
  - gate_cnt increments every cycle.
  - Each cycle with edge=1 increments edge_cnt.
  - If edge_cnt==2^CNT_W-1 at an edge, it holds and sat is set.
  - On the cycle with gate_cnt==GATE_CYCLES-1, an edge in that same cycle is included.
  - At the end of that cycle: count_out <= final count, overflow <= sat (or the final edge saturating), valid <= 1, state -> HOLD.
  - start and cont are ignored during GATE.
- HOLD:
  - count_out and overflow are stable while valid=1.
  - Handshake: transfer occurs on a cycle with valid&ready. valid drops the next cycle.
  - Next state on transfer: ARM if cont=1 that cycle, else IDLE.
  - With ready=0, stay in HOLD indefinitely. No new gate starts, so no result is ever overwritten.
  - ready may be high before valid; the transfer then completes on the first HOLD cycle.
- count_out and overflow keep their last value after the transfer until the next gate completes.
- Latency (one-shot): start high in cycle 0 -> ARM in cycle 1 -> GATE in cycles 2..GATE_CYCLES+1 -> valid=1 from cycle GATE_CYCLES+2.
- Continuous mode with ready tied high:
  - one result per GATE_CYCLES+2 cycles;
  - valid is a 1-cycle pulse;
  - the input is blind during the HOLD and ARM cycles.
- Arithmetic: gate_cnt width is clog2(GATE_CYCLES). All counters are unsigned and never wrap.

Optional Feature:
- Macro: FREQ_METER_BOTH_EDGES_EN.
- Defined: edge = sync_out ^ hist, so both rising and falling transitions are counted (count is twice the frequency per gate). Saturation rules are unchanged.
- Undefined: rising edges only, as specified above.

Test Plan:
- GATE_CYCLES=100, CNT_W=24; sig_in square wave with period 10 clk, start pulse -> valid at cycle 102 after start, count_out=10 (±1 for phase), overflow=0.
- sig_in held at 1 from before start, one-shot -> count_out=0, overflow=0; state returns to IDLE after ready.
- CNT_W=4, GATE_CYCLES=100, sig_in period 4 (25 edges) -> count_out=15, overflow=1.
- cont=1, ready held low for 50 cycles after valid:
  - valid, count_out and overflow stay stable and busy=1;
  - after the ready pulse, valid falls next cycle and the next valid appears 102 cycles after the transfer.
- rst_n pulsed low at gate cycle 40 -> outputs are immediately 0 and IDLE; no valid until a new start; the new measurement with period 10 yields 10.
- FREQ_METER_BOTH_EDGES_EN defined, GATE_CYCLES=100, period 10 -> count_out=20 (±1).
